view_window_ctrl: RTL and testbench

- Parametrised scroll controller for the seven-segment result display.
- Moves a WINDOW-digit view across an NUM_DIGITS-digit value, using BTNL, BTNR and BTNC (home).
- Adds three things: per-button debouncing, auto-repeat while a button is held, and optional wrap-around.
- Drives the digit-select offset and a visible-digit mask into the display mux.

---
 rtl/display_pkg.sv | 35 +++
 rtl/view_window_ctrl_if.sv | 25 ++
 rtl/btn_debounce.sv | 56 +++++
 rtl/view_window_ctrl.sv | 153 +++++++++++++++
 tb/tb_view_window_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants, widths and enums for the display scroll logic.
// Timing is expressed in ms and converted to cycles of the system clock.
package display_pkg;

  localparam int NUM_DIGITS_DEF  = 6;
  localparam int WINDOW_DEF      = 4;

  localparam int CLK_HZ          = 100_000_000;
  localparam int DEBOUNCE_MS     = 10;
  localparam int REPEAT_DELAY_MS = 500;
  localparam int REPEAT_RATE_MS  = 150;

  function automatic int ms_to_cyc(int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYC_DEF     = ms_to_cyc(DEBOUNCE_MS);
  localparam int REPEAT_DELAY_CYC_DEF = ms_to_cyc(REPEAT_DELAY_MS);
  localparam int REPEAT_RATE_CYC_DEF  = ms_to_cyc(REPEAT_RATE_MS);

  function automatic int ofs_width(int max_ofs);
    return (max_ofs < 1) ? 1 : $clog2(max_ofs + 1);
  endfunction

  function automatic int cnt_width(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

endpackage

// File: rtl/view_window_ctrl_if.sv
// Button inputs and view outputs of the scroll controller.
// The slave side is the controller, the master side drives the buttons.
interface view_window_ctrl_if #(
    parameter int NUM_DIGITS = 6,
    parameter int OFS_W      = 2
);
    logic                  btn_l;
    logic                  btn_r;
    logic                  btn_c;
    logic [OFS_W-1:0]      ofs;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  at_min;
    logic                  at_max;
    logic                  step;

    modport master (
        output btn_l, btn_r, btn_c,
        input  ofs, digit_en, at_min, at_max, step
    );

    modport slave (
        input  btn_l, btn_r, btn_c,
        output ofs, digit_en, at_min, at_max, step
    );
endinterface

// File: rtl/btn_debounce.sv
// Two-FF synchroniser, stable-level debouncer and one-cycle press pulse.
// A button already held when reset drops must be released before it can press.
module btn_debounce
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic db_o,
    output logic press_o
);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic [1:0]       fill_q;
    logic             armed_q;
    logic             db_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sync;
    logic             flip;

    assign sync = sync_q[1];
    assign flip = (sync != db_q) && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            fill_q  <= '0;
            armed_q <= 1'b0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            fill_q  <= {fill_q[0], 1'b1};
            // arm only once the synchroniser holds real samples showing release
            armed_q <= armed_q | (fill_q[1] & ~sync);
            press_q <= flip & sync & armed_q;
            if (sync == db_q) begin
                cnt_q <= '0;
            end else if (flip) begin
                db_q  <= sync;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign db_o    = db_q;
    assign press_o = press_q;
endmodule

// File: rtl/view_window_ctrl.sv
// Scrolls a WINDOW-digit view across a NUM_DIGITS value with debounced
// L/R/home buttons, auto-repeat while held and optional wrap-around.
module view_window_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS       = NUM_DIGITS_DEF,
    parameter int WINDOW           = WINDOW_DEF,
    parameter int DEBOUNCE_CYC     = DEBOUNCE_CYC_DEF,
    parameter int REPEAT_DELAY_CYC = REPEAT_DELAY_CYC_DEF,
    parameter int REPEAT_RATE_CYC  = REPEAT_RATE_CYC_DEF,
    parameter bit WRAP             = 1'b0
) (
    input logic         clk,
    input logic         rst,
    view_window_ctrl_if.slave win
);
    localparam int MAX_OFS = NUM_DIGITS - WINDOW;
    localparam int OFS_W   = ofs_width(MAX_OFS);
    localparam logic [OFS_W-1:0] MAX_V = OFS_W'(MAX_OFS);

    localparam int RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                             REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RPT_W   = cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE_CYC - 1);

    logic [1:0] db_lr;
    logic [1:0] press_lr;
    logic [1:0] req;
    logic       db_c;
    logic       press_c;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_l (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (win.btn_l),
        .db_o    (db_lr[0]),
        .press_o (press_lr[0])
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_r (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (win.btn_r),
        .db_o    (db_lr[1]),
        .press_o (press_lr[1])
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_c (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (win.btn_c),
        .db_o    (db_c),
        .press_o (press_c)
    );

    // index 0 = L, 1 = R
    for (genvar g = 0; g < 2; g++) begin : g_rpt
        rpt_state_e       state_q;
        logic [RPT_W-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (rst || !db_lr[g]) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (press_lr[g]) begin
                            state_q <= DELAY;
                            cnt_q   <= '0;
                        end
                    end
                    DELAY: begin
                        if (cnt_q == DLY_LAST) begin
                            state_q <= REPEAT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (cnt_q == RATE_LAST) cnt_q <= '0;
                        else                    cnt_q <= cnt_q + 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign req[g] = db_lr[g] &&
            ((state_q == IDLE   && press_lr[g]) ||
             (state_q == DELAY  && cnt_q == DLY_LAST) ||
             (state_q == REPEAT && cnt_q == RATE_LAST));
    end

    function automatic logic [NUM_DIGITS-1:0] win_mask(logic [OFS_W-1:0] o);
        logic [NUM_DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            m[i] = (i >= int'(o)) && (i < int'(o) + WINDOW);
        end
        return m;
    endfunction

    logic [OFS_W-1:0]      ofs_q;
    logic [OFS_W-1:0]      ofs_d;
    logic [NUM_DIGITS-1:0] en_q;
    logic                  at_min_q;
    logic                  at_max_q;
    logic                  step_q;

    // home beats motion; holding L and R together freezes the view
    always_comb begin
        ofs_d = ofs_q;
        if (press_c) begin
            ofs_d = '0;
        end else if (!(db_lr[0] && db_lr[1])) begin
            if (req[1]) begin
                if (ofs_q != MAX_V) ofs_d = ofs_q + 1'b1;
                else if (WRAP)      ofs_d = '0;
            end else if (req[0]) begin
                if (ofs_q != '0) ofs_d = ofs_q - 1'b1;
                else if (WRAP)   ofs_d = MAX_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ofs_q    <= '0;
            en_q     <= win_mask('0);
            at_min_q <= 1'b1;
            at_max_q <= (MAX_OFS == 0);
            step_q   <= 1'b0;
        end else begin
            ofs_q    <= ofs_d;
            en_q     <= win_mask(ofs_d);
            at_min_q <= (ofs_d == '0);
            at_max_q <= (ofs_d == MAX_V);
            step_q   <= (ofs_d != ofs_q);
        end
    end

    assign win.ofs      = ofs_q;
    assign win.digit_en = en_q;
    assign win.at_min   = at_min_q;
    assign win.at_max   = at_max_q;
    assign win.step     = step_q;
endmodule

// File: tb/tb_view_window_ctrl.sv
// Scoreboard bench for view_window_ctrl: saturating, wrapping and
// degenerate instances, with expected steps queued at stimulus time.
module tb_view_window_ctrl;
    import display_pkg::*;

    localparam int DEB  = 4;
    localparam int DLY  = 20;
    localparam int RATE = 5;
    localparam int LAT  = DEB + 3;
    localparam int OW_A = ofs_width(2);
    localparam int OW_B = ofs_width(4);
    localparam int OW_C = ofs_width(0);

    typedef struct {
        int cyc;
        int ofs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    view_window_ctrl_if #(.NUM_DIGITS(6), .OFS_W(OW_A)) ia ();
    view_window_ctrl_if #(.NUM_DIGITS(8), .OFS_W(OW_B)) ib ();
    view_window_ctrl_if #(.NUM_DIGITS(6), .OFS_W(OW_C)) ic ();

    view_window_ctrl #(
        .NUM_DIGITS(6), .WINDOW(4), .DEBOUNCE_CYC(DEB),
        .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE), .WRAP(1'b0)
    ) u_a (.clk(clk), .rst(rst_a), .win(ia));

    view_window_ctrl #(
        .NUM_DIGITS(8), .WINDOW(4), .DEBOUNCE_CYC(DEB),
        .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE), .WRAP(1'b1)
    ) u_b (.clk(clk), .rst(rst_b), .win(ib));

    view_window_ctrl #(
        .NUM_DIGITS(6), .WINDOW(6), .DEBOUNCE_CYC(DEB),
        .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE), .WRAP(1'b0)
    ) u_c (.clk(clk), .rst(rst_c), .win(ic));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(string tag, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int steps_a = 0;
    int steps_b = 0;
    int steps_c = 0;

    always @(negedge clk) begin
        if (!rst_a && ia.step) begin
            steps_a++;
            if (qa.size() == 0) begin
                check("a_extra_step", 1, 0);
            end else begin
                ea = qa.pop_front();
                check("a_step_ofs", int'(ia.ofs), ea.ofs);
                check("a_step_cyc", cyc, ea.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && ib.step) begin
            steps_b++;
            if (qb.size() == 0) begin
                check("b_extra_step", 1, 0);
            end else begin
                eb = qb.pop_front();
                check("b_step_ofs", int'(ib.ofs), eb.ofs);
                check("b_step_cyc", cyc, eb.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_c && ic.step) begin
            steps_c++;
            check("c_extra_step", 1, 0);
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(int d, int o);
        exp_t e;
        e.cyc = cyc + d;
        e.ofs = o;
        qa.push_back(e);
    endtask

    task automatic push_b(int d, int o);
        exp_t e;
        e.cyc = cyc + d;
        e.ofs = o;
        qb.push_back(e);
    endtask

    task automatic tap_a_r(int hold);
        ia.btn_r = 1'b1;
        tick(hold);
        ia.btn_r = 1'b0;
        tick(12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ia.btn_l = 0; ia.btn_r = 0; ia.btn_c = 0;
        ib.btn_l = 0; ib.btn_r = 0; ib.btn_c = 0;
        ic.btn_l = 0; ic.btn_r = 0; ic.btn_c = 0;
        tick(3);
        rst_a = 0; rst_b = 0; rst_c = 0;
        tick(1);
        check("a_rst_ofs", int'(ia.ofs), 0);
        check("a_rst_en", int'(ia.digit_en), 6'b001111);
        check("a_rst_min", int'(ia.at_min), 1);
        check("a_rst_max", int'(ia.at_max), 0);
        check("a_rst_step", int'(ia.step), 0);
        check("b_rst_en", int'(ib.digit_en), 8'b00001111);
        check("c_rst_en", int'(ic.digit_en), 6'b111111);
        check("c_rst_max", int'(ic.at_max), 1);
        tick(5);

        push_a(LAT, 1); tap_a_r(10);
        push_a(LAT, 2); tap_a_r(10);
        tap_a_r(10);
        check("a_sat_ofs", int'(ia.ofs), 2);
        check("a_sat_en", int'(ia.digit_en), 6'b111100);
        check("a_sat_max", int'(ia.at_max), 1);
        check("a_sat_min", int'(ia.at_min), 0);
        check("a_sat_steps", steps_a, 2);

        rst_a = 1; tick(2); rst_a = 0; tick(4);
        check("a_rst2_ofs", int'(ia.ofs), 0);
        ia.btn_r = 1; tick(3); ia.btn_r = 0; tick(15);
        check("a_glitch_ofs", int'(ia.ofs), 0);
        check("a_glitch_steps", steps_a, 2);
        push_a(LAT, 1); tap_a_r(6);
        check("a_stable_ofs", int'(ia.ofs), 1);
        check("a_stable_steps", steps_a, 3);

        push_a(LAT, 2); tap_a_r(10);
        ia.btn_l = 1; ia.btn_r = 1; tick(40);
        check("a_conflict_ofs", int'(ia.ofs), 2);
        push_a(LAT, 0);
        ia.btn_c = 1; tick(8); ia.btn_c = 0; tick(12);
        check("a_home_ofs", int'(ia.ofs), 0);
        check("a_home_min", int'(ia.at_min), 1);
        ia.btn_c = 1; tick(8); ia.btn_c = 0; tick(12);
        check("a_home0_steps", steps_a, 5);
        ia.btn_l = 0; ia.btn_r = 0; tick(12);
        check("a_release_ofs", int'(ia.ofs), 0);

        push_a(LAT, 1); tap_a_r(10);
        push_a(LAT, 2);
        ia.btn_r = 1; tick(40);
        rst_a = 1; tick(1);
        check("a_midrst_ofs", int'(ia.ofs), 0);
        rst_a = 0; tick(40);
        check("a_held_ofs", int'(ia.ofs), 0);
        check("a_held_steps", steps_a, 7);
        ia.btn_r = 0; tick(12);
        push_a(LAT, 1); tap_a_r(6);
        check("a_repress_ofs", int'(ia.ofs), 1);

        push_b(LAT, 1);
        push_b(LAT + DLY, 2);
        push_b(LAT + DLY + RATE, 3);
        push_b(LAT + DLY + 2 * RATE, 4);
        push_b(LAT + DLY + 3 * RATE, 0);
        ib.btn_r = 1; tick(38); ib.btn_r = 0; tick(20);
        check("b_wrap_ofs", int'(ib.ofs), 0);
        check("b_wrap_en", int'(ib.digit_en), 8'b00001111);
        check("b_wrap_steps", steps_b, 5);
        push_b(LAT, 4);
        ib.btn_l = 1; tick(10); ib.btn_l = 0; tick(12);
        check("b_lwrap_ofs", int'(ib.ofs), 4);
        check("b_lwrap_en", int'(ib.digit_en), 8'b11110000);
        check("b_lwrap_max", int'(ib.at_max), 1);

        ic.btn_r = 1; tick(40); ic.btn_r = 0; tick(12);
        ic.btn_l = 1; tick(10); ic.btn_l = 0; tick(12);
        ic.btn_c = 1; tick(8); ic.btn_c = 0; tick(12);
        ic.btn_l = 1; ic.btn_r = 1; tick(30);
        ic.btn_l = 0; ic.btn_r = 0; tick(12);
        check("c_ofs", int'(ic.ofs), 0);
        check("c_min", int'(ic.at_min), 1);
        check("c_max", int'(ic.at_max), 1);
        check("c_en", int'(ic.digit_en), 6'b111111);
        check("c_steps", steps_c, 0);

        check("a_missing_steps", qa.size(), 0);
        check("b_missing_steps", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
